// File: rtl/fetch_unit.sv
// Instruction fetch stage. It holds the PC, reads 16-bit words from a
// 1-cycle-latency instruction memory and presents them to the decoder
// as opcode/operand over a valid/ready handshake.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | stopped; waiting for run
//   S_FETCH | imem read strobe asserted at address pc
//   S_WAIT  | read data arrives; captured into output registers on edge
//   S_ISSUE | instruction presented; held until the decoder accepts it
module fetch_unit #(
  parameter int               ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [7:0]        IDLE_OP  = 8'hFF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              run_i,
  output logic              imem_rd_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [15:0]       imem_rdata_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [7:0]        instr_opcode_o,
  output logic [7:0]        instr_operand_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  input  logic              jump_to_addr_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_ISSUE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q;
  logic [7:0]        opcode_q;
  logic [7:0]        operand_q;
  logic [ADDR_W-1:0] ipc_q;
  logic              handshake;

  // A jump or PC advance only happens on an accepted instruction.
  assign handshake = (state_q == S_ISSUE) && valid_q && instr_ready_i;

  // State and PC registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state and next-PC logic; the PC wraps naturally at 2**ADDR_W.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_IDLE:  if (run_i) state_d = S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  state_d = S_ISSUE;
      S_ISSUE: begin
        if (handshake) begin
          pc_d    = jump_to_addr_i ? ADDR_W'(operand_q) : pc_q + ADDR_W'(1);
          state_d = run_i ? S_FETCH : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state only.
  always_comb begin
    imem_rd_o = (state_q == S_FETCH);
    busy_o    = (state_q != S_IDLE);
  end

  // Instruction output registers: loaded as read data lands, cleared on accept.
  // The opcode falls back to IDLE_OP whenever nothing valid is presented.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q   <= 1'b0;
      opcode_q  <= IDLE_OP;
      operand_q <= 8'h00;
      ipc_q     <= RESET_PC;
    end else if (state_q == S_WAIT) begin
      valid_q   <= 1'b1;
      opcode_q  <= imem_rdata_i[15:8];
      operand_q <= imem_rdata_i[7:0];
      ipc_q     <= pc_q;
    end else if (handshake) begin
      valid_q   <= 1'b0;
      opcode_q  <= IDLE_OP;
    end
  end

  assign imem_addr_o     = pc_q;
  assign instr_valid_o   = valid_q;
  assign instr_opcode_o  = opcode_q;
  assign instr_operand_o = operand_q;
  assign instr_pc_o      = ipc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a transaction-level model of the fetch
// pipeline (architectural PC, fetch/present timing, jump/advance rule).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        imem_rd;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic [7:0]  instr_operand;
  logic [7:0]  instr_pc;
  logic        jump_to_addr;
  logic        busy;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .run_i          (run),
    .imem_rd_o      (imem_rd),
    .imem_addr_o    (imem_addr),
    .imem_rdata_i   (imem_rdata),
    .instr_valid_o  (instr_valid),
    .instr_ready_i  (instr_ready),
    .instr_opcode_o (instr_opcode),
    .instr_operand_o(instr_operand),
    .instr_pc_o     (instr_pc),
    .jump_to_addr_i (jump_to_addr),
    .busy_o         (busy)
  );

  // Instruction memory: 1-cycle read latency, garbage on the bus otherwise.
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (imem_rd) imem_rdata <= mem[imem_addr];
    else         imem_rdata <= 16'($urandom);
  end

  int checks = 0;
  int fails  = 0;
  bit chk_en = 0;

  // Reference model state.
  int m_pc;
  bit m_busy, m_rd, m_wait, m_pres;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_busy = 0; m_rd = 0; m_wait = 0; m_pres = 0;
  endtask

  // One clock: drive inputs, check outputs at negedge, advance model, take edge.
  // jmode: 0 never jump, 1 jump when presented opcode is 02, 2 random jump flag.
  task automatic cyc(input bit rn, input bit rn_run, input bit rdy, input int jmode);
    bit jmp;
    bit n_rd, n_wait, n_pres, n_busy;
    int n_pc;
    case (jmode)
      1:       jmp = m_pres && (mem[m_pc][15:8] == 8'h02);
      2:       jmp = ($urandom % 3) == 0;
      default: jmp = 0;
    endcase
    rst_n = rn; run = rn_run; instr_ready = rdy; jump_to_addr = jmp;
    @(negedge clk);
    if (chk_en) begin
      chk("imem_rd", 16'(imem_rd), 16'(m_rd));
      if (m_rd) chk("imem_addr", 16'(imem_addr), 16'(m_pc));
      chk("instr_valid", 16'(instr_valid), 16'(m_pres));
      chk("busy", 16'(busy), 16'(m_busy));
      if (m_pres) begin
        chk("opcode", 16'(instr_opcode), 16'(mem[m_pc][15:8]));
        chk("operand", 16'(instr_operand), 16'(mem[m_pc][7:0]));
        chk("instr_pc", 16'(instr_pc), 16'(m_pc));
      end else begin
        chk("idle_opcode", 16'(instr_opcode), 16'h00FF);
      end
    end
    n_rd = 0; n_wait = m_rd; n_pres = m_pres | m_wait; n_busy = m_busy; n_pc = m_pc;
    if (!m_busy && rn_run) begin n_rd = 1; n_busy = 1; end
    if (m_pres && rdy) begin
      n_pc   = jmp ? int'(mem[m_pc][7:0]) : (m_pc + 1) % 256;
      n_pres = 0;
      n_rd   = rn_run;
      n_busy = rn_run;
    end
    m_rd = n_rd; m_wait = n_wait; m_pres = n_pres; m_busy = n_busy; m_pc = n_pc;
    if (!rn) model_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    rst_n = 0; run = 0; instr_ready = 0; jump_to_addr = 0;
    model_reset();

    // Reset with run low: reset values, nothing fetched.
    cyc(0, 0, 0, 0);
    chk_en = 1;
    chk("rst_valid", 16'(instr_valid), 16'h0000);
    chk("rst_opcode", 16'(instr_opcode), 16'h00FF);
    chk("rst_operand", 16'(instr_operand), 16'h0000);
    chk("rst_instr_pc", 16'(instr_pc), 16'h0000);
    chk("rst_imem_addr", 16'(imem_addr), 16'h0000);
    chk("rst_imem_rd", 16'(imem_rd), 16'h0000);
    chk("rst_busy", 16'(busy), 16'h0000);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0);

    // Straight-line fetch of three instructions, then stop.
    mem[0] = 16'h0311; mem[1] = 16'h0422; mem[2] = 16'h0533; mem[3] = 16'h0100;
    for (int i = 0; i < 10; i++) cyc(1, 1, 1, 0);
    k = 0;
    while (m_busy && k < 20) begin cyc(1, 0, 1, 0); k++; end
    chk("stop_idle", 16'(busy), 16'h0000);

    // Jump taken from address 1 to 8'h40.
    cyc(0, 0, 0, 0);
    mem[0] = 16'h0311; mem[1] = 16'h0240; mem[8'h40] = 16'h0777; mem[8'h41] = 16'h0888;
    for (int i = 0; i < 12; i++) cyc(1, 1, 1, 1);
    k = 0;
    while (m_busy && k < 20) begin cyc(1, 0, 1, 0); k++; end

    // Backpressure: ready held low for 5 cycles while 06aa is presented.
    cyc(0, 0, 0, 0);
    mem[0] = 16'h06AA;
    k = 0;
    while (!m_pres && k < 20) begin cyc(1, 1, 0, 0); k++; end
    chk("bp_presented", 16'(instr_valid), 16'h0001);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 2);
    cyc(1, 0, 1, 0);
    k = 0;
    while (m_busy && k < 20) begin cyc(1, 0, 1, 0); k++; end

    // Wrap at 8'hFF with run dropped during the read.
    cyc(0, 0, 0, 0);
    mem[0] = 16'h02FF; mem[8'hFF] = 16'h095C;
    k = 0;
    while (!(m_wait && m_pc == 255) && k < 30) begin cyc(1, 1, 1, 1); k++; end
    k = 0;
    while (m_busy && k < 20) begin cyc(1, 0, 1, 1); k++; end
    chk("wrap_idle_busy", 16'(busy), 16'h0000);
    cyc(1, 1, 1, 0);
    chk("wrap_restart_rd", 16'(imem_rd), 16'h0001);
    chk("wrap_restart_addr", 16'(imem_addr), 16'h0000);
    k = 0;
    while (m_busy && k < 20) begin cyc(1, 0, 1, 0); k++; end

    // Reset during the read, then restart with run high.
    mem[1] = 16'h0ABC;
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0);
    k = 0;
    while (!m_wait && k < 20) begin cyc(1, 1, 1, 0); k++; end
    cyc(0, 1, 1, 0);
    chk("abandon_valid", 16'(instr_valid), 16'h0000);
    for (int i = 0; i < 8; i++) cyc(1, 1, 1, 0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 800; i++)
      cyc(($urandom % 64) != 0, ($urandom % 8) != 0, ($urandom % 3) != 0, 2);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
